microinstruction_fetch: RTL

MICROINSTRUCTION_FETCH -- requirements
Module: microinstruction_fetch

---
 rtl/microinstruction_fetch.sv | 139 +++++++++++++
 1 files changed

// File: rtl/microinstruction_fetch.sv
`timescale 1ns/1ps
// Microinstruction fetch stage.
// Holds the micro-PC (UADDR) that addresses the control store. It registers the
// returned control word into the issued field outputs one cycle later.
// A small IDLE/RUN/HALT controller sequences start, stall, flush,
// branch redirects and the HALT microinstruction.
module microinstruction_fetch #(
  parameter logic [8:0] RESET_ADDR = 9'h000,
  parameter logic [3:0] HALT_ALU   = 4'hF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [8:0]  branch_addr,
  output logic [8:0]  UADDR,
  input  logic [31:0] UWORD,
  output logic [3:0]  ALU3,
  output logic [1:0]  SH3,
  output logic [5:0]  C3,
  output logic [6:0]  T3,
  output logic [10:0] DATA_ADDR_3,
  output logic [1:0]  M3,
  output logic        VALID3
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [8:0]  uaddr_next;
  logic [8:0]  uaddr_inc;

  // The issued word is kept packed exactly as it arrives from the control store.
  logic [31:0] issue_word;
  logic [31:0] issue_word_next;
  logic        issue_valid;
  logic        issue_valid_next;

  logic        uword_is_halt;

  // The micro-PC wraps modulo 512 with no carry out.
  assign uaddr_inc = UADDR + 9'd1;

  // HALT is identified by the ALU opcode together with M = 2'b11.
  assign uword_is_halt = (UWORD[31:28] == HALT_ALU) && (UWORD[1:0] == 2'b11);

  assign ALU3        = issue_word[31:28];
  assign SH3         = issue_word[27:26];
  assign C3          = issue_word[25:20];
  assign T3          = issue_word[19:13];
  assign DATA_ADDR_3 = issue_word[12:2];
  assign M3          = issue_word[1:0];
  assign VALID3      = issue_valid;

  // The state register is cleared to IDLE the moment reset drops.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The micro-PC and issued fields are cleared on reset so nothing partial survives.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      UADDR       <= RESET_ADDR;
      issue_word  <= 32'h0000_0000;
      issue_valid <= 1'b0;
    end else begin
      UADDR       <= uaddr_next;
      issue_word  <= issue_word_next;
      issue_valid <= issue_valid_next;
    end
  end

  // Next-state, next micro-PC and next issued fields. Priority in RUN is branch, then flush, then stall.
  always_comb begin
    state_next       = state;
    uaddr_next       = UADDR;
    issue_word_next  = issue_word;
    issue_valid_next = issue_valid;

    unique case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
        end
      end

      RUN: begin
        if (branch_taken) begin
          uaddr_next       = branch_addr;
          issue_word_next  = 32'h0000_0000;
          issue_valid_next = 1'b0;
        end else if (flush) begin
          uaddr_next       = uaddr_inc;
          issue_word_next  = 32'h0000_0000;
          issue_valid_next = 1'b0;
        end else if (stall) begin
          uaddr_next       = UADDR;
        end else begin
          issue_word_next  = UWORD;
          issue_valid_next = 1'b1;
          if (uword_is_halt) begin
            uaddr_next = UADDR;
            state_next = HALT;
          end else begin
            uaddr_next = uaddr_inc;
          end
        end
      end

      HALT: begin
        issue_word_next  = 32'h0000_0000;
        issue_valid_next = 1'b0;
        if (start) begin
          uaddr_next = uaddr_inc;
          state_next = RUN;
        end
      end

      default: begin
        state_next       = IDLE;
        issue_word_next  = 32'h0000_0000;
        issue_valid_next = 1'b0;
      end
    endcase
  end

endmodule
